// File: rtl/blit_mem_pkg.sv
// rtl/blit_mem_pkg.sv - shared types and byte-lane helpers for the blitter memory responder
package blit_mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_OTHER,
      S_WR,
      S_RDREQ,
      S_RDWAIT,
      S_ACK
   } state_t;

   localparam logic [3:0] WIDTH_PHRASE = 4'd0;

   // Lanes start..start+n-1 within one phrase; lanes beyond 7 fall off the end.
   function automatic logic [7:0] be_mask(input logic [2:0] start, input logic [3:0] count);
      logic [3:0] n;
      logic [7:0] m;
      n = (count == WIDTH_PHRASE) ? 4'd8 : count;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if ((4'(i) >= {1'b0, start}) && (5'(i) < ({2'b00, start} + {1'b0, n})))
            m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/blit_mem_resp_if.sv
// rtl/blit_mem_resp_if.sv - blitter bus, arbitration and backend memory signals
interface blit_mem_resp_if #(
   parameter int ADDR_W = 24
);
   logic [1:0]        blit_breq;
   logic              blit_back;
   logic              other_breq;
   logic              other_back;
   logic [ADDR_W-1:0] blit_addr;
   logic              mreq;
   logic              read;
   logic [3:0]        width;
   logic              justify;
   logic [63:0]       wdata;
   logic              ack;
   logic [63:0]       data;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-4:0] mem_addr;
   logic [7:0]        mem_be;
   logic [63:0]       mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [63:0]       mem_rdata;

   modport slave (
      input  blit_breq, other_breq, blit_addr, mreq, read, width, justify, wdata,
             mem_ready, mem_rvalid, mem_rdata,
      output blit_back, other_back, ack, data, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output blit_breq, other_breq, blit_addr, mreq, read, width, justify, wdata,
             mem_ready, mem_rvalid, mem_rdata,
      input  blit_back, other_back, ack, data, mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/blit_lane_align.sv
// rtl/blit_lane_align.sv - byte enables and justify shifters for write and read paths
module blit_lane_align
   import blit_mem_pkg::*;
(
   input  logic [2:0]  i_start,
   input  logic [3:0]  i_width,
   input  logic        i_justify,
   input  logic [63:0] i_wdata,
   input  logic [63:0] i_rdata,
   output logic [7:0]  o_be,
   output logic [63:0] o_wdata,
   output logic [63:0] o_rdata
);
   logic [5:0]  w_shift;
   logic [7:0]  w_keep;
   logic [63:0] w_keep_bits;

   always_comb begin
      w_shift = {i_start, 3'b000};
      o_be    = be_mask(i_start, i_width);
      w_keep  = be_mask(3'd0, i_width);
      for (int i = 0; i < 8; i++)
         w_keep_bits[8*i +: 8] = {8{w_keep[i]}};
      o_wdata = i_justify ? (i_wdata << w_shift) : i_wdata;
      // Justified reads return only the requested bytes, packed at bit 0.
      o_rdata = i_justify ? ((i_rdata >> w_shift) & w_keep_bits) : i_rdata;
   end
endmodule

// File: rtl/blit_mem_resp.sv
// rtl/blit_mem_resp.sv - blitter bus arbiter and responder onto a phrase-wide memory port
module blit_mem_resp
   import blit_mem_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int ADDR_W   = 24
) (
   input  logic             i_sys_clk,
   input  logic             i_xreset_n,
   blit_mem_resp_if.slave   bus
);
   localparam int HW = $clog2(HOLD_MAX + 1);

   state_t            r_state;
   logic [HW-1:0]     r_hold;
   logic              r_blit_back;
   logic              r_other_back;
   logic              r_ack;
   logic [63:0]       r_data;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-4:0] r_mem_addr;
   logic [7:0]        r_mem_be;
   logic [63:0]       r_mem_wdata;
   logic [2:0]        r_start;
   logic [3:0]        r_width;
   logic              r_justify;

   logic              w_blit_wins;
   logic              w_count;
   logic              w_expire;
   logic              w_in_grant;
   logic [2:0]        w_start;
   logic [3:0]        w_width;
   logic              w_justify;
   logic [7:0]        w_be;
   logic [63:0]       w_wdata;
   logic [63:0]       w_rdata;

   assign w_blit_wins = bus.blit_breq[1] | (bus.blit_breq[0] & ~bus.other_breq);
   assign w_count     = r_blit_back & bus.other_breq & ~bus.blit_breq[1];
   // Expire on the cycle that brings the count to HOLD_MAX, so exactly HOLD_MAX cycles are held.
   assign w_expire    = (r_hold == HW'(HOLD_MAX)) || (w_count && (r_hold == HW'(HOLD_MAX - 1)));

   assign w_in_grant = (r_state == S_GRANT);
   assign w_start    = w_in_grant ? bus.blit_addr[2:0] : r_start;
   assign w_width    = w_in_grant ? bus.width          : r_width;
   assign w_justify  = w_in_grant ? bus.justify        : r_justify;

   blit_lane_align u_align (
      .i_start   (w_start),
      .i_width   (w_width),
      .i_justify (w_justify),
      .i_wdata   (bus.wdata),
      .i_rdata   (bus.mem_rdata),
      .o_be      (w_be),
      .o_wdata   (w_wdata),
      .o_rdata   (w_rdata)
   );

   always_ff @(posedge i_sys_clk or negedge i_xreset_n) begin
      if (!i_xreset_n) begin
         r_state      <= S_IDLE;
         r_hold       <= '0;
         r_blit_back  <= 1'b0;
         r_other_back <= 1'b0;
         r_ack        <= 1'b0;
         r_data       <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_be     <= '0;
         r_mem_wdata  <= '0;
         r_start      <= '0;
         r_width      <= '0;
         r_justify    <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_blit_wins)
            r_hold <= '0;
         else if (w_count && r_hold != HW'(HOLD_MAX))
            r_hold <= r_hold + HW'(1);

         case (r_state)
            S_IDLE: begin
               if (w_blit_wins) begin
                  r_state     <= S_GRANT;
                  r_blit_back <= 1'b1;
               end else if (bus.other_breq) begin
                  r_state      <= S_OTHER;
                  r_other_back <= 1'b1;
               end
            end
            S_OTHER: begin
               if (!bus.other_breq) begin
                  r_state      <= S_IDLE;
                  r_other_back <= 1'b0;
               end
            end
            S_GRANT: begin
               if (bus.mreq) begin
                  r_start     <= bus.blit_addr[2:0];
                  r_width     <= bus.width;
                  r_justify   <= bus.justify;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= ~bus.read;
                  r_mem_addr  <= bus.blit_addr[ADDR_W-1:3];
                  r_mem_be    <= w_be;
                  r_mem_wdata <= w_wdata;
                  r_state     <= bus.read ? S_RDREQ : S_WR;
               end else if (bus.blit_breq == 2'b00 || w_expire) begin
                  r_state     <= S_IDLE;
                  r_blit_back <= 1'b0;
               end
            end
            S_WR: begin
               if (bus.mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_ack     <= 1'b1;
                  r_state   <= S_ACK;
               end
            end
            S_RDREQ: begin
               if (bus.mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               if (bus.mem_rvalid) begin
                  r_data  <= w_rdata;
                  r_ack   <= 1'b1;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               r_ack   <= 1'b0;
               r_state <= S_GRANT;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.blit_back  = r_blit_back;
   assign bus.other_back = r_other_back;
   assign bus.ack        = r_ack;
   assign bus.data       = r_data;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_be     = r_mem_be;
   assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_blit_mem_resp.sv
// tb/tb_blit_mem_resp.sv - directed self-checking bench for blit_mem_resp
module tb_blit_mem_resp;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   blit_mem_resp_if #(.ADDR_W(24)) bus ();

   blit_mem_resp #(.HOLD_MAX(16), .ADDR_W(24)) dut (
      .i_sys_clk  (clk),
      .i_xreset_n (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.blit_breq  = 2'b00;
      bus.other_breq = 1'b0;
      bus.blit_addr  = '0;
      bus.mreq       = 1'b0;
      bus.read       = 1'b0;
      bus.width      = 4'd0;
      bus.justify    = 1'b0;
      bus.wdata      = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (bus.blit_back !== 1'b0 || bus.other_back !== 1'b0) begin errors++; $display("FAIL rst_back got=%b%b exp=00", bus.blit_back, bus.other_back); end
      checks++; if (bus.ack !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_ctl got ack=%b req=%b we=%b exp=0", bus.ack, bus.mem_req, bus.mem_we); end
      checks++; if (bus.mem_be !== 8'h00 || bus.mem_addr !== 21'h0 || bus.mem_wdata !== 64'h0 || bus.data !== 64'h0) begin errors++; $display("FAIL rst_data got be=%h addr=%h wd=%h d=%h exp=0", bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.data); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write;
      bus.blit_breq = 2'b01;
      tick();
      checks++; if (bus.blit_back !== 1'b1) begin errors++; $display("FAIL wr_grant got=%b exp=1", bus.blit_back); end
      bus.mreq = 1'b1; bus.read = 1'b0; bus.blit_addr = 24'h001005; bus.width = 4'd2;
      bus.justify = 1'b1; bus.wdata = 64'h000000000000BEEF; bus.mem_ready = 1'b1;
      tick();
      bus.mreq = 1'b0;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_req got req=%b we=%b exp=11", bus.mem_req, bus.mem_we); end
      checks++; if (bus.mem_addr !== 21'h000200) begin errors++; $display("FAIL wr_addr got=%h exp=000200", bus.mem_addr); end
      checks++; if (bus.mem_be !== 8'h60) begin errors++; $display("FAIL wr_be got=%h exp=60", bus.mem_be); end
      checks++; if (bus.mem_wdata !== 64'h00BEEF0000000000) begin errors++; $display("FAIL wr_wdata got=%h exp=00beef0000000000", bus.mem_wdata); end
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early got=%b exp=0", bus.ack); end
      tick();
      checks++; if (bus.ack !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL wr_ack got ack=%b req=%b exp=1,0", bus.ack, bus.mem_req); end
      bus.mem_ready = 1'b0;
      tick();
      checks++; if (bus.ack !== 1'b0 || bus.blit_back !== 1'b1) begin errors++; $display("FAIL wr_ack_pulse got ack=%b back=%b exp=0,1", bus.ack, bus.blit_back); end
   endtask

   task automatic test_read_justify;
      bus.mreq = 1'b1; bus.read = 1'b1; bus.blit_addr = 24'h000003; bus.width = 4'd1;
      bus.justify = 1'b1; bus.mem_ready = 1'b1;
      tick();
      bus.mreq = 1'b0;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 8'h08) begin errors++; $display("FAIL rd_req got req=%b we=%b be=%h exp=1,0,08", bus.mem_req, bus.mem_we, bus.mem_be); end
      tick();
      bus.mem_ready = 1'b0;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop got=%b exp=0", bus.mem_req); end
      repeat (2) begin
         tick();
         checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rd_wait_ack got=%b exp=0", bus.ack); end
      end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1122334455667788;
      tick();
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.ack !== 1'b1 || bus.data !== 64'h55) begin errors++; $display("FAIL rd_just got ack=%b data=%h exp=1,55", bus.ack, bus.data); end
      tick();
      checks++; if (bus.ack !== 1'b0 || bus.data !== 64'h55) begin errors++; $display("FAIL rd_hold got ack=%b data=%h exp=0,55", bus.ack, bus.data); end
      bus.mreq = 1'b1; bus.justify = 1'b0; bus.mem_ready = 1'b1;
      tick();
      bus.mreq = 1'b0;
      tick();
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.ack !== 1'b1 || bus.data !== 64'h1122334455667788) begin errors++; $display("FAIL rd_full got ack=%b data=%h exp=1,1122334455667788", bus.ack, bus.data); end
      tick();
   endtask

   task automatic test_lane_trunc;
      bus.mreq = 1'b1; bus.read = 1'b0; bus.blit_addr = 24'h000006; bus.width = 4'd4;
      bus.justify = 1'b0; bus.wdata = 64'h000000000000CAFE; bus.mem_ready = 1'b0;
      tick();
      bus.mreq = 1'b0;
      checks++; if (bus.mem_be !== 8'hC0 || bus.mem_wdata !== 64'h000000000000CAFE) begin errors++; $display("FAIL trunc got be=%h wd=%h exp=c0,cafe", bus.mem_be, bus.mem_wdata); end
      tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.ack !== 1'b0) begin errors++; $display("FAIL trunc_hold got req=%b ack=%b exp=1,0", bus.mem_req, bus.ack); end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL trunc_ack got=%b exp=1", bus.ack); end
      tick();
      bus.mreq = 1'b1; bus.blit_addr = 24'h000010; bus.width = 4'd0; bus.justify = 1'b1;
      bus.wdata = 64'h0123456789ABCDEF; bus.mem_ready = 1'b1;
      tick();
      bus.mreq = 1'b0;
      checks++; if (bus.mem_be !== 8'hFF || bus.mem_wdata !== 64'h0123456789ABCDEF || bus.mem_addr !== 21'h000002) begin errors++; $display("FAIL phrase got be=%h wd=%h a=%h exp=ff,0123456789abcdef,2", bus.mem_be, bus.mem_wdata, bus.mem_addr); end
      tick();
      bus.mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_arbitration;
      bus.blit_breq = 2'b00;
      tick();
      checks++; if (bus.blit_back !== 1'b0) begin errors++; $display("FAIL arb_release got=%b exp=0", bus.blit_back); end
      bus.blit_breq = 2'b01; bus.other_breq = 1'b1;
      tick();
      checks++; if (bus.other_back !== 1'b1 || bus.blit_back !== 1'b0) begin errors++; $display("FAIL arb_other got o=%b b=%b exp=1,0", bus.other_back, bus.blit_back); end
      tick();
      bus.other_breq = 1'b0;
      tick();
      checks++; if (bus.other_back !== 1'b0 || bus.blit_back !== 1'b0) begin errors++; $display("FAIL arb_gap got o=%b b=%b exp=0,0", bus.other_back, bus.blit_back); end
      tick();
      checks++; if (bus.blit_back !== 1'b1) begin errors++; $display("FAIL arb_after_gap got=%b exp=1", bus.blit_back); end
      bus.blit_breq = 2'b00;
      tick();
      bus.blit_breq = 2'b10; bus.other_breq = 1'b1;
      tick();
      checks++; if (bus.blit_back !== 1'b1 || bus.other_back !== 1'b0) begin errors++; $display("FAIL arb_hipri got b=%b o=%b exp=1,0", bus.blit_back, bus.other_back); end
   endtask

   task automatic test_preempt;
      int  n;
      bit  found;
      n = 0;
      found = 1'b0;
      bus.blit_breq = 2'b01;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         n++;
         if (bus.blit_back !== 1'b1) found = 1'b1;
      end
      checks++; if (!found || n != 16) begin errors++; $display("FAIL preempt_len got=%0d found=%0d exp=16", n, found); end
      tick();
      checks++; if (bus.other_back !== 1'b1 || bus.blit_back !== 1'b0) begin errors++; $display("FAIL preempt_other got o=%b b=%b exp=1,0", bus.other_back, bus.blit_back); end
      bus.other_breq = 1'b0;
      tick();
      tick();
      checks++; if (bus.blit_back !== 1'b1) begin errors++; $display("FAIL preempt_regrant got=%b exp=1", bus.blit_back); end
   endtask

   task automatic test_preempt_inflight;
      bus.other_breq = 1'b1;
      repeat (14) tick();
      checks++; if (bus.blit_back !== 1'b1) begin errors++; $display("FAIL inflight_pre got=%b exp=1", bus.blit_back); end
      bus.mreq = 1'b1; bus.read = 1'b1; bus.blit_addr = 24'h000020; bus.width = 4'd0;
      bus.justify = 1'b0; bus.mem_ready = 1'b0;
      tick();
      bus.mreq = 1'b0;
      tick();
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hA5A5A5A55A5A5A5A;
      tick();
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.ack !== 1'b1 || bus.blit_back !== 1'b1 || bus.data !== 64'hA5A5A5A55A5A5A5A) begin errors++; $display("FAIL inflight_ack got ack=%b b=%b d=%h exp=1,1,a5a5a5a55a5a5a5a", bus.ack, bus.blit_back, bus.data); end
      tick();
      checks++; if (bus.ack !== 1'b0 || bus.blit_back !== 1'b1) begin errors++; $display("FAIL inflight_grant got ack=%b b=%b exp=0,1", bus.ack, bus.blit_back); end
      tick();
      checks++; if (bus.blit_back !== 1'b0) begin errors++; $display("FAIL inflight_release got=%b exp=0", bus.blit_back); end
      tick();
      checks++; if (bus.other_back !== 1'b1) begin errors++; $display("FAIL inflight_other got=%b exp=1", bus.other_back); end
      bus.other_breq = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_midread;
      bus.mreq = 1'b1; bus.read = 1'b1; bus.blit_addr = 24'h000003; bus.width = 4'd1;
      bus.justify = 1'b1; bus.mem_ready = 1'b1;
      tick();
      bus.mreq = 1'b0;
      tick();
      bus.mem_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.blit_back !== 1'b0 || bus.mem_req !== 1'b0 || bus.ack !== 1'b0) begin errors++; $display("FAIL rst_async got b=%b req=%b ack=%b exp=0", bus.blit_back, bus.mem_req, bus.ack); end
      checks++; if (bus.data !== 64'h0 || bus.mem_be !== 8'h00 || bus.mem_addr !== 21'h0) begin errors++; $display("FAIL rst_async_data got d=%h be=%h a=%h exp=0", bus.data, bus.mem_be, bus.mem_addr); end
      bus.blit_breq = 2'b00; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hFFFFFFFFFFFFFFFF;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack got=%b exp=0", bus.ack); end
      end
      bus.mem_rvalid = 1'b0;
      bus.mreq = 1'b1;
      tick();
      bus.mreq = 1'b0;
      checks++; if (bus.mem_req !== 1'b0 || bus.blit_back !== 1'b0) begin errors++; $display("FAIL ungranted_mreq got req=%b b=%b exp=0,0", bus.mem_req, bus.blit_back); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_justify();
      test_lane_trunc();
      test_arbitration();
      test_preempt();
      test_preempt_inflight();
      test_reset_midread();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/blit_mem_resp.md
Name: blit_mem_resp

Overview:
- Bus-side responder for the blitter's memory master port: arbitrates bus ownership (blit_breq/blit_back) against one other master and captures each blitter cycle (address, width, read/write, justify, wdata).
- Executes each cycle on a phrase-wide backend memory port and returns ack plus read data.
- Sits between the blitter and the memory controller, replacing the system-level arbiter/slave for blitter traffic.

Parameters:
- HOLD_MAX, 16: max cycles the blitter keeps the bus while other_breq is pending and blit_breq[1]=0.
- ADDR_W, 24: byte address width; phrase address is ADDR_W-3 bits.

Ports:
- sys_clk  in  1  system clock, all state on rising edge
- xreset_n  in  1  asynchronous active-low reset
- blit_breq  in  2  blitter bus request; [0] normal, [1] high priority
- blit_back  out  1  bus granted to blitter
- other_breq  in  1  bus request from the other master
- other_back  out  1  bus granted to the other master
- blit_addr  in  ADDR_W  byte address of cycle
- mreq  in  1  cycle strobe, sampled only while blit_back=1
- read  in  1  1=read, 0=write
- width  in  4  byte count 1..8; 0 means 8
- justify  in  1  data right-justified to bit 0
- wdata  in  64  write data
- ack  out  1  one-cycle completion pulse
- data  out  64  read data, valid with ack, held until next read ack
- mem_req  out  1  backend request, held until accepted
- mem_we  out  1  backend write
- mem_addr  out  ADDR_W-3  phrase address = blit_addr[ADDR_W-1:3]
- mem_be  out  8  byte enables
- mem_wdata  out  64  lane-aligned write data
- mem_ready  in  1  backend accepts request this cycle
- mem_rvalid  in  1  read data valid; never in the same cycle as the read's mem_ready
- mem_rdata  in  64  backend read data

Behaviour:
- Reset: all outputs 0; state IDLE; hold counter 0; capture registers 0.
- States: IDLE, GRANT, OTHER, WR, RDREQ, RDWAIT, ACK.
- IDLE priority: blit_breq[1] > other_breq > blit_breq[0]. Blitter wins -> GRANT with blit_back=1 next cycle. Other wins -> OTHER with other_back=1.
- OTHER: stay while other_breq=1; on drop -> IDLE (one-cycle gap, no grant).
- GRANT:
  - mreq=1 -> capture addr/read/width/justify/wdata, then -> WR or RDREQ.
  - else blit_breq=0 -> IDLE, blit_back drops next cycle.
  - else preempt flag set -> IDLE.
  - mreq wins over a simultaneous blit_breq drop or preempt.
- Hold counter: counts every grant cycle in which other_breq=1 and blit_breq[1]=0; cleared on entering GRANT from IDLE. Reaching HOLD_MAX sets the preempt flag. Preemption takes effect only in GRANT; an in-flight transaction always completes.
- blit_back stays 1 in WR/RDREQ/RDWAIT/ACK.
- Byte enables: s=addr[2:0], n=(width==0)?8:width. be bits s..min(s+n-1,7) set; lanes past 7 are dropped, with no phrase crossing.
- Write data: justify=1 -> mem_wdata=wdata<<(8*s); else wdata unchanged.
- WR: mem_req=1, mem_we=1 until mem_ready sampled -> ACK.
- RDREQ: mem_req=1, mem_we=0, mem_be as computed; on mem_ready -> RDWAIT.
- RDWAIT: on mem_rvalid, data register loads mem_rdata>>(8*s) with bytes above n-1 zeroed if justify=1, else full mem_rdata; -> ACK.
- ACK: ack=1 for exactly one cycle -> GRANT.
- Latency: mreq at cycle N -> mem_req from N+1. Write: ack one cycle after mem_ready, minimum N+2. Read: ack one cycle after mem_rvalid, minimum N+3.
- mreq outside GRANT (including during ACK): ignored, never queued.
- Asynchronous reset mid-transaction: immediate return to reset values; the backend tolerates an abandoned mem_req.

Decomposition:
- Package blit_mem_pkg: state enum, WIDTH_PHRASE=4'd0, function be_mask(start,count).
- One sub-module, blit_lane_align: combinational be generation plus write/read justify shifters, shared by the write and read paths.

Test Plan:
- Write, granted: blit_breq=01, mreq with addr=0x001005, width=2, justify=1, wdata=0xBEEF, mem_ready immediate -> mem_addr=0x000200, mem_be=0x60, mem_wdata=0x00BEEF0000000000, ack at N+2.
- Justified read: addr=0x000003, width=1, rdata=0x1122334455667788, mem_rvalid 3 cycles after accept -> data=0x55, ack one cycle after rvalid. Same with justify=0 -> full phrase returned.
- Lane truncation: addr[2:0]=6, width=4 -> mem_be=0xC0.
- Arbitration: other_breq and blit_breq=01 asserted together from IDLE -> other_back first. blit_breq=10 instead -> blit_back first.
- Preemption: blitter granted, other_breq=1, HOLD_MAX=16, no mreq -> blit_back drops after 16 counted cycles, then other_back=1. With a read in flight at expiry -> ack delivered first, then release.
- Reset during RDWAIT -> all outputs 0 immediately; no ack after reset release; mreq while ungranted produces no mem_req.
